serial_pair_serializer: RTL and testbench
=========================================

SERIAL_PAIR_SERIALIZER -- requirements
Module: serial_pair_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width in bits; legal range 1..32.
REQ-002 Port clk, input, 1, the single clock; all state SHALL change on the rising edge.
REQ-003 Port rst, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 Port up_valid, input, 1, marks a parallel word pair as present.
REQ-005 Port up_ready, output, 1, marks that the block accepts the word pair this cycle.
REQ-006 Port up_a, input, WIDTH, parallel word A.
REQ-007 Port up_b, input, WIDTH, parallel word B.
REQ-008 Port a, output, 1, the current serial bit of A.
REQ-009 Port b, output, 1, the current serial bit of B.
REQ-010 Port serial_valid, output, 1, marks a and b as carrying a valid bit.
REQ-011 Port first, output, 1, marks the first bit of a word.
REQ-012 Port last, output, 1, marks the last bit of a word.
REQ-013 Port down_ready, input, 1, consumer backpressure; the block advances one bit only when serial_valid and down_ready are both 1.

Function
REQ-014 The block SHALL use an FSM with states IDLE (serial_valid=0) and SHIFT (serial_valid=1).
- It SHALL also have one active shift register pair, a bit counter of $clog2(WIDTH)+1 bits, and a one-entry hold buffer.
REQ-015 By default, bit order SHALL be MSB first: bit index WIDTH-1 down to 0.
REQ-016 up_ready SHALL equal NOT hold_full.
- It SHALL be driven from registers only, with no combinational path from up_valid or down_ready.
REQ-017 A word SHALL be accepted at a rising edge with up_valid and up_ready both 1. The accepted word SHALL go:
- into the shifter, when it is IDLE or is completing its last bit at that same edge;
- otherwise into the hold buffer.
REQ-018 Latency: a word accepted at edge N SHALL present its first bit with first=1 during the cycle following edge N, when the shifter was free.
REQ-019 When the last bit completes and hold_full=1:
- the hold word SHALL load at the same edge;
- its first bit SHALL appear the next cycle with no bubble;
- hold_full SHALL clear at that edge.
REQ-020 If a new word is accepted at the same edge that the hold buffer drains, the new word SHALL enter the hold buffer.
REQ-021 When the last bit completes and no word is available, the FSM SHALL return to IDLE.
REQ-022 While serial_valid=1 and down_ready=0, a, b, first and last SHALL remain stable.
REQ-023 a, b, first and last SHALL be 0 whenever serial_valid=0.
REQ-024 When WIDTH=1, first and last SHALL both be 1 on the single bit.
REQ-025 With down_ready held at 1, sustained throughput SHALL be one word per WIDTH cycles.

Reset
REQ-026 Asserting rst SHALL immediately force the following, regardless of clk:
- serial_valid=0, a=0, b=0, first=0, last=0;
- FSM=IDLE, hold_full=0, counter=0;
- up_ready=1.
REQ-027 Assertion of rst mid-word SHALL discard the partial word and any held word.
- The first word accepted after deassertion SHALL start with first=1.

Configuration
REQ-028 With macro SERIAL_PAIR_LSB_FIRST_EN defined, bit order SHALL be LSB first (index 0 up to WIDTH-1).
- first and last SHALL keep marking word start and end.
REQ-029 Without SERIAL_PAIR_LSB_FIRST_EN defined, bit order SHALL be MSB first.

Structure
REQ-030 Package serial_pkg SHALL hold:
- the FSM state enum typedef (IDLE, SHIFT);
- the default width constant SERIAL_WIDTH_DEFAULT=8.
REQ-031 One sub-module, serial_pair_hold_buffer, SHALL implement the one-entry hold register and its full flag. All other logic SHALL be in-line.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, all at WIDTH=4:
- V1: up_a=4'b1010, up_b=4'b0110, down_ready=1 -> a=1,0,1,0; b=0,1,1,0; serial_valid=1 for exactly 4 cycles; first on bit 1; last on bit 4.
- V2: three words back-to-back with up_valid held at 1 -> 12 contiguous serial_valid cycles with no bubble; up_ready=0 while hold_full.
- V3: down_ready=0 for 3 cycles at bit 2 -> a, b, first and last frozen; no bit lost or duplicated; word completes 3 cycles late.
- V4: rst asserted at bit 2 -> outputs 0 with no clock edge; up_ready=1; next word (4'b0011) starts with first=1.
- V5: SERIAL_PAIR_LSB_FIRST_EN defined, up_a=4'b1000 -> a=0,0,0,1.
- V6: outputs drive the MSB-first serial comparator, with its reset pulsed on first, up_a=5, up_b=9 -> a_less_b=1 on the last bit.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pair serializer.
package serial_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 32'd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serial_state_e;

endpackage

// File: rtl/serial_pair_hold_buffer.sv
// One-entry skid register for a word pair; full flag drives upstream ready.
module serial_pair_hold_buffer
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             full
);

    logic [WIDTH-1:0] hold_a_r;
    logic [WIDTH-1:0] hold_b_r;
    logic             full_r;

    // Capture a word when loaded; release the full flag when the shifter takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_a_r <= {WIDTH{1'b0}};
            hold_b_r <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
        end else if (load) begin
            hold_a_r <= in_a;
            hold_b_r <= in_b;
            full_r   <= 1'b1;
        end else if (drain) begin
            full_r   <= 1'b0;
        end
    end

    assign out_a = hold_a_r;
    assign out_b = hold_b_r;
    assign full  = full_r;

endmodule

// File: rtl/serial_pair_serializer.sv
// Parallel word pair to serial bit pair converter with one-word hold buffer.
// Bit order is MSB first unless SERIAL_PAIR_LSB_FIRST_EN is defined.
module serial_pair_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             a,
    output logic             b,
    output logic             serial_valid,
    output logic             first,
    output logic             last,
    input  logic             down_ready
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SERIAL_PAIR_LSB_FIRST_EN
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return w >> 1'b1;
    endfunction
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return w[0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return w << 1'b1;
    endfunction
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return w[WIDTH-1];
    endfunction
`endif

    serial_state_e    state_r, state_next_s;
    logic [WIDTH-1:0] sh_a_r, sh_b_r, sh_a_next_s, sh_b_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic             a_r, b_r, first_r, last_r;
    logic             a_next_s, b_next_s, first_next_s, last_next_s;

    logic             hold_full_s;
    logic [WIDTH-1:0] hold_a_s, hold_b_s;
    logic [WIDTH-1:0] load_a_s, load_b_s;
    logic             accept_s, advance_s, last_done_s, free_s;
    logic             load_new_s, load_hold_s, to_hold_s;

    // up_ready comes straight from the hold flag register, so no input reaches it.
    assign up_ready    = ~hold_full_s;
    assign accept_s    = up_valid & ~hold_full_s;
    assign advance_s   = (state_r == SHIFT) & down_ready;
    assign last_done_s = advance_s & last_r;
    assign free_s      = (state_r == IDLE) | last_done_s;
    assign load_hold_s = last_done_s & hold_full_s;
    assign load_new_s  = accept_s & free_s;
    assign to_hold_s   = accept_s & ~free_s;
    assign load_a_s    = load_hold_s ? hold_a_s : up_a;
    assign load_b_s    = load_hold_s ? hold_b_s : up_b;

    serial_pair_hold_buffer #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (to_hold_s),
        .drain (load_hold_s),
        .in_a  (up_a),
        .in_b  (up_b),
        .out_a (hold_a_s),
        .out_b (hold_b_s),
        .full  (hold_full_s)
    );

    // Next-state and next-output logic: load beats go-idle beats plain advance.
    always_comb begin
        state_next_s = state_r;
        sh_a_next_s  = sh_a_r;
        sh_b_next_s  = sh_b_r;
        cnt_next_s   = cnt_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        first_next_s = first_r;
        last_next_s  = last_r;
        if (load_new_s || load_hold_s) begin
            state_next_s = SHIFT;
            sh_a_next_s  = load_a_s;
            sh_b_next_s  = load_b_s;
            cnt_next_s   = {CW{1'b0}};
            a_next_s     = lead_bit(load_a_s);
            b_next_s     = lead_bit(load_b_s);
            first_next_s = 1'b1;
            last_next_s  = (LAST_IDX == {CW{1'b0}});
        end else if (last_done_s) begin
            state_next_s = IDLE;
            cnt_next_s   = {CW{1'b0}};
            a_next_s     = 1'b0;
            b_next_s     = 1'b0;
            first_next_s = 1'b0;
            last_next_s  = 1'b0;
        end else if (advance_s) begin
            sh_a_next_s  = shift_word(sh_a_r);
            sh_b_next_s  = shift_word(sh_b_r);
            cnt_next_s   = cnt_r + 1'b1;
            a_next_s     = lead_bit(sh_a_next_s);
            b_next_s     = lead_bit(sh_b_next_s);
            first_next_s = 1'b0;
            last_next_s  = (cnt_next_s == LAST_IDX);
        end else begin
            state_next_s = state_r;
        end
    end

    // State, shifter and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            sh_a_r  <= {WIDTH{1'b0}};
            sh_b_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sh_a_r  <= sh_a_next_s;
            sh_b_r  <= sh_b_next_s;
            cnt_r   <= cnt_next_s;
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            first_r <= first_next_s;
            last_r  <= last_next_s;
        end
    end

    assign serial_valid = (state_r == SHIFT);
    assign a            = a_r;
    assign b            = b_r;
    assign first        = first_r;
    assign last         = last_r;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Directed, table-driven bench for serial_pair_serializer at WIDTH=4.
module tb_serial_pair_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid, up_ready;
    logic [3:0] up_a, up_b;
    logic       a, b, serial_valid, first, last, down_ready;

    int checks = 0;
    int errors = 0;

    serial_pair_serializer #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_a         (up_a),
        .up_b         (up_b),
        .a            (a),
        .b            (b),
        .serial_valid (serial_valid),
        .first        (first),
        .last         (last),
        .down_ready   (down_ready)
    );

    always #5 clk = ~clk;

    // MSB-first serial comparator fed by the serializer outputs.
    logic cmp_lt_r, cmp_gt_r, a_less_b;
    always_comb begin
        if (first) a_less_b = ~a & b;
        else       a_less_b = cmp_lt_r | (~cmp_gt_r & ~a & b);
    end
    always @(posedge clk) begin
        if (serial_valid && down_ready) begin
            cmp_lt_r <= a_less_b;
            cmp_gt_r <= first ? (a & ~b) : (cmp_gt_r | (~cmp_lt_r & a & ~b));
        end
    end

    // seq[3] is the first bit on the wire, seq[0] the last.
    typedef struct {
        logic [3:0] in_a;
        logic [3:0] in_b;
        logic [3:0] msb_a;
        logic [3:0] msb_b;
        logic [3:0] lsb_a;
        logic [3:0] lsb_b;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] wire_seq(input logic [3:0] w);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
        return {w[0], w[1], w[2], w[3]};
`else
        return w;
`endif
    endfunction

    task automatic check_bit(input string name, input int k, input logic [3:0] sa, input logic [3:0] sb);
        check($sformatf("%s.valid[%0d]", name, k), serial_valid, 1'b1);
        check($sformatf("%s.a[%0d]", name, k), a, sa[3-k]);
        check($sformatf("%s.b[%0d]", name, k), b, sb[3-k]);
        check($sformatf("%s.first[%0d]", name, k), first, (k == 0));
        check($sformatf("%s.last[%0d]", name, k), last, (k == 3));
    endtask

    task automatic check_idle(input string name);
        check({name, ".valid"}, serial_valid, 1'b0);
        check({name, ".abfl"}, {a, b, first, last}, 4'b0000);
    endtask

    task automatic send(input logic [3:0] wa, input logic [3:0] wb);
        up_valid = 1'b1;
        up_a     = wa;
        up_b     = wb;
        step();
        up_valid = 1'b0;
    endtask

    task automatic expect_seq(input string name, input logic [3:0] sa, input logic [3:0] sb);
        for (int k = 0; k < 4; k++) begin
            check_bit(name, k, sa, sb);
            step();
        end
    endtask

    logic [3:0] v2_a[3];
    logic [3:0] v2_b[3];
    logic       v2_rdy[12];
    int         wi;
    logic       acc;

    initial begin
        vecs[0] = '{4'b1010, 4'b0110, 4'b1010, 4'b0110, 4'b0101, 4'b0110};
        vecs[1] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        vecs[2] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b1000};
        vecs[3] = '{4'b0011, 4'b1101, 4'b0011, 4'b1101, 4'b1100, 4'b1011};
        v2_a = '{4'b1100, 4'b0101, 4'b1001};
        v2_b = '{4'b0011, 4'b1111, 4'b0000};
        v2_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b0; up_valid = 1'b0; up_a = 4'b0000; up_b = 4'b0000; down_ready = 1'b1;
        #3;
        check_idle("reset");
        check("reset.up_ready", up_ready, 1'b1);
        step();
        rst = 1'b1;
        step();
        check_idle("post_reset");

        // V1/V5 and friends: single words through the table.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].in_a, vecs[i].in_b);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
            expect_seq($sformatf("vec%0d", i), vecs[i].lsb_a, vecs[i].lsb_b);
`else
            expect_seq($sformatf("vec%0d", i), vecs[i].msb_a, vecs[i].msb_b);
`endif
            check_idle($sformatf("vec%0d.end", i));
        end

        // V2: three words back-to-back, up_valid held high.
        wi = 0;
        send(v2_a[0], v2_b[0]);
        wi = 1;
        up_valid = 1'b1; up_a = v2_a[1]; up_b = v2_b[1];
        for (int c = 0; c < 12; c++) begin
            check_bit($sformatf("v2.w%0d", c / 4), c % 4, wire_seq(v2_a[c / 4]), wire_seq(v2_b[c / 4]));
            check($sformatf("v2.up_ready[%0d]", c), up_ready, v2_rdy[c]);
            acc = up_valid & up_ready;
            step();
            if (acc) wi++;
            if (wi < 3) begin
                up_a = v2_a[wi]; up_b = v2_b[wi];
            end else begin
                up_valid = 1'b0;
            end
        end
        check_idle("v2.end");

        // V3: stall three cycles on the second bit.
        send(4'b1010, 4'b0110);
        check_bit("v3", 0, wire_seq(4'b1010), wire_seq(4'b0110));
        step();
        down_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_bit($sformatf("v3.stall%0d", s), 1, wire_seq(4'b1010), wire_seq(4'b0110));
            step();
        end
        check_bit("v3.resume", 1, wire_seq(4'b1010), wire_seq(4'b0110));
        down_ready = 1'b1;
        step();
        check_bit("v3", 2, wire_seq(4'b1010), wire_seq(4'b0110));
        step();
        check_bit("v3", 3, wire_seq(4'b1010), wire_seq(4'b0110));
        step();
        check_idle("v3.end");

        // V4: async reset mid-word with a word sitting in the hold buffer.
        send(4'b1100, 4'b1010);
        send(4'b0111, 4'b0111);
        check("v4.up_ready_held", up_ready, 1'b0);
        check_bit("v4.pre", 1, wire_seq(4'b1100), wire_seq(4'b1010));
        #2 rst = 1'b0;
        #1;
        check_idle("v4.rst");
        check("v4.up_ready", up_ready, 1'b1);
        #1 rst = 1'b1;
        step();
        send(4'b0011, 4'b0101);
        expect_seq("v4.next", wire_seq(4'b0011), wire_seq(4'b0101));
        check_idle("v4.end");
        step();
        check_idle("v4.no_held");

`ifndef SERIAL_PAIR_LSB_FIRST_EN
        // V6: serial comparator on the MSB-first stream.
        send(4'd5, 4'd9);
        for (int k = 0; k < 3; k++) step();
        check("v6.last", last, 1'b1);
        check("v6.a_less_b", a_less_b, 1'b1);
        step();
        send(4'd9, 4'd5);
        for (int k = 0; k < 3; k++) step();
        check("v6r.last", last, 1'b1);
        check("v6r.a_less_b", a_less_b, 1'b0);
        step();
        check_idle("v6.end");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
